u2_gray_codec_pipe: RTL and testbench

//  Parametrised, pipelined two's-complement (U2) <-> Gray codec for the SPI execution unit.

---
 rtl/u2_gray_pkg.sv | 19 +
 rtl/u2_gray_stage.sv | 32 +++
 rtl/u2_gray_codec_pipe.sv | 68 ++++++
 tb/tb_u2_gray_codec_pipe.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/u2_gray_pkg.sv
// u2_gray_pkg: mode encoding and the per-stage record carried down the U2/Gray codec pipe.
// MAXW bounds the operand width; the codec uses the low BITS bits of data/partial.
package u2_gray_pkg;
  localparam int MAXW = 64;
  typedef enum logic [1:0] {
    U2_TO_GRAY  = 2'b00,
    GRAY_TO_U2  = 2'b01,
    ABS_TO_GRAY = 2'b10,
    RESERVED    = 2'b11
  } codec_mode_t;
  typedef struct packed {
    logic             valid;
    codec_mode_t      mode;
    logic             err;
    logic [MAXW-1:0]  data;
    logic [MAXW-1:0]  partial;
    logic             carry;
  } stage_t;
endpackage

// File: rtl/u2_gray_stage.sv
// u2_gray_stage: resolves C bits of the Gray->binary prefix XOR below the bits already done,
// starting from the carry of the stage above, and registers the slot on advance.
module u2_gray_stage
  import u2_gray_pkg::*;
#(
  parameter int BITS = 8,
  parameter int C    = 4,
  parameter int K    = 1
) (
  input  logic   i_clk,
  input  logic   i_rstn,
  input  logic   i_adv,
  input  stage_t i_prev,
  output stage_t o_q
);
  stage_t s_d, s_q;
  logic   c;
  always_comb begin
    s_d = i_prev;
    c = i_prev.carry;
    for (int j = BITS-1-K*C; j >= BITS-(K+1)*C; j--) begin
      c = c ^ i_prev.data[j];
      if (i_prev.mode == GRAY_TO_U2 && !i_prev.err) s_d.partial[j] = c;
    end
    s_d.carry = c;
  end
  always_ff @(posedge i_clk) begin
    if (!i_rstn) s_q <= '0;
    else if (i_adv) s_q <= s_d;
  end
  assign o_q = s_q;
endmodule

// File: rtl/u2_gray_codec_pipe.sv
// u2_gray_codec_pipe: pipelined U2<->Gray codec with valid/ready on both sides.
// Stage 0 is inline; the remaining STAGES-1 stages finish the Gray decode chunk by chunk.
module u2_gray_codec_pipe
  import u2_gray_pkg::*;
#(
  parameter int BITS   = 8,
  parameter int STAGES = 2
) (
  input  logic            i_clk,
  input  logic            i_rstn,
  input  logic            i_valid,
  output logic            o_ready,
  input  logic [1:0]      i_mode,
  input  logic [BITS-1:0] i_argA,
  output logic            o_valid,
  input  logic            i_ready,
  output logic [BITS-1:0] o_result,
  output logic            o_err
);
  localparam int C = BITS / STAGES;
  localparam logic [BITS-1:0] MIN_NEG = {1'b1, {(BITS-1){1'b0}}};
  codec_mode_t     mode;
  logic [BITS-1:0] mag, pfx;
  logic            adv, c, err;
  stage_t          s0_d, s0_q;
  stage_t          st [STAGES];
  assign mode = codec_mode_t'(i_mode);
  assign mag = i_argA[BITS-1] ? -i_argA : i_argA;
  // U2 encode and Gray decode both reject a set sign bit; abs only rejects the most negative value
  assign err = mode == RESERVED || (mode == ABS_TO_GRAY ? i_argA == MIN_NEG : i_argA[BITS-1]);
  assign adv = !o_valid || i_ready;
  assign o_ready = adv;
  always_comb begin
    pfx = '0;
    c = 1'b0;
    for (int j = BITS-1; j >= BITS-C; j--) begin
      c = c ^ i_argA[j];
      pfx[j] = c;
    end
    s0_d = '0;
    s0_d.valid = i_valid;
    s0_d.mode = mode;
    s0_d.err = err;
    s0_d.data[BITS-1:0] = i_argA;
    s0_d.carry = c;
    s0_d.partial[BITS-1:0] = err ? '0 :
                             mode == GRAY_TO_U2  ? pfx :
                             mode == ABS_TO_GRAY ? mag ^ (mag >> 1) :
                             i_argA ^ (i_argA >> 1);
  end
  always_ff @(posedge i_clk) begin
    if (!i_rstn) s0_q <= '0;
    else if (adv) s0_q <= s0_d;
  end
  assign st[0] = s0_q;
  for (genvar k = 1; k < STAGES; k++) begin : g_stage
    u2_gray_stage #(.BITS(BITS), .C(C), .K(k)) u_stage (
      .i_clk  (i_clk),
      .i_rstn (i_rstn),
      .i_adv  (adv),
      .i_prev (st[k-1]),
      .o_q    (st[k])
    );
  end
  assign o_valid  = st[STAGES-1].valid;
  assign o_err    = st[STAGES-1].err;
  assign o_result = st[STAGES-1].partial[BITS-1:0];
endmodule

// File: tb/tb_u2_gray_codec_pipe.sv
// tb_u2_gray_codec_pipe: drives three codec instances (STAGES 2, 1, 8) with shared stimulus and
// checks each against a slot-level behavioural model every cycle, plus directed literal vectors.
module tb_u2_gray_codec_pipe;
  localparam int N = 3;
  typedef struct packed { logic [1:0] md; logic [7:0] a; logic [7:0] r; logic e; } vec_t;
  localparam vec_t VECS [12] = '{
    '{2'b00, 8'h05, 8'h07, 1'b0}, '{2'b00, 8'h7F, 8'h40, 1'b0}, '{2'b00, 8'h80, 8'h00, 1'b1},
    '{2'b01, 8'h07, 8'h05, 1'b0}, '{2'b01, 8'h40, 8'h7F, 1'b0}, '{2'b01, 8'hC0, 8'h00, 1'b1},
    '{2'b10, 8'hFB, 8'h07, 1'b0}, '{2'b10, 8'h05, 8'h07, 1'b0}, '{2'b10, 8'h80, 8'h00, 1'b1},
    '{2'b11, 8'h05, 8'h00, 1'b1}, '{2'b10, 8'hFF, 8'h01, 1'b0}, '{2'b01, 8'h00, 8'h00, 1'b0}
  };
  logic       clk = 1'b0, rstn = 1'b0, vin = 1'b0, rin = 1'b1;
  logic [1:0] mode = 2'b00;
  logic [7:0] arg = 8'h00;
  logic       vout [N], rdy [N], eout [N];
  logic [7:0] res [N];
  int         checks = 0, errors = 0;
  int         dut_acc [N], dut_emit [N];
  bit         mv [N][8], me [N][8];
  logic [7:0] mr [N][8];
  bit         hold [N];
  logic [7:0] pr [N];
  logic       pe [N];

  always #5 clk = ~clk;

  for (genvar g = 0; g < N; g++) begin : g_dut
    u2_gray_codec_pipe #(.BITS(8), .STAGES(g == 0 ? 2 : g == 1 ? 1 : 8)) dut (
      .i_clk    (clk),
      .i_rstn   (rstn),
      .i_valid  (vin),
      .o_ready  (rdy[g]),
      .i_mode   (mode),
      .i_argA   (arg),
      .o_valid  (vout[g]),
      .i_ready  (rin),
      .o_result (res[g]),
      .o_err    (eout[g])
    );
  end

  function automatic int st_of(int m);
    return m == 0 ? 2 : m == 1 ? 1 : 8;
  endfunction

  // {err, result} from the arithmetic definition of each mode
  function automatic logic [8:0] ref_op(logic [1:0] md, logic [7:0] a);
    int v;
    logic [7:0] m, b;
    case (md)
      2'b00: return a[7] ? 9'h100 : {1'b0, a ^ (a >> 1)};
      2'b01: begin
        if (a[7]) return 9'h100;
        b = 8'h00;
        for (int s = 0; s < 8; s++) b = b ^ (a >> s);
        return {1'b0, b};
      end
      2'b10: begin
        if (a == 8'h80) return 9'h100;
        v = a[7] ? 256 - int'(a) : int'(a);
        m = v[7:0];
        return {1'b0, m ^ (m >> 1)};
      end
      default: return 9'h100;
    endcase
  endfunction

  task automatic chk(string name, int m, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s inst%0d: got %0h expected %0h", name, m, act, exp);
    end
  endtask

  initial forever begin
    @(posedge clk);
    for (int m = 0; m < N; m++) begin
      int s;
      s = st_of(m);
      hold[m] = rstn && vout[m] && !rin;
      pr[m] = res[m];
      pe[m] = eout[m];
      if (rstn && vin && rdy[m]) dut_acc[m]++;
      if (rstn && vout[m] && rin) dut_emit[m]++;
      if (!rstn) begin
        for (int k = 0; k < 8; k++) mv[m][k] = 1'b0;
      end else if (!mv[m][s-1] || rin) begin
        for (int k = s - 1; k > 0; k--) begin
          mv[m][k] = mv[m][k-1];
          mr[m][k] = mr[m][k-1];
          me[m][k] = me[m][k-1];
        end
        {me[m][0], mr[m][0]} = ref_op(mode, arg);
        mv[m][0] = vin;
      end
    end
    #1;
    for (int m = 0; m < N; m++) begin
      int s;
      s = st_of(m);
      chk("o_valid", m, vout[m], mv[m][s-1]);
      if (mv[m][s-1]) begin
        chk("o_result", m, res[m], mr[m][s-1]);
        chk("o_err", m, eout[m], me[m][s-1]);
      end
      chk("o_ready", m, rdy[m], !mv[m][s-1] || rin);
      if (hold[m]) begin
        chk("hold_valid", m, vout[m], 1);
        chk("hold_result", m, res[m], pr[m]);
        chk("hold_err", m, eout[m], pe[m]);
      end
    end
  end

  task automatic cyc(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drain();
    vin = 1'b0;
    rin = 1'b1;
    cyc(12);
  endtask

  task automatic run_one(input logic [1:0] md, input logic [7:0] a, output logic [7:0] r, output logic e);
    bit got;
    got = 1'b0;
    r = 8'h00;
    e = 1'b0;
    @(negedge clk);
    mode = md;
    arg = a;
    vin = 1'b1;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk);
      vin = 1'b0;
      if (vout[0]) begin
        got = 1'b1;
        r = res[0];
        e = eout[0];
      end
    end
    chk("run_one_timeout", 0, got, 1);
  endtask

  task automatic lat_check(input logic [1:0] md, input logic [7:0] a);
    int lat [N];
    for (int m = 0; m < N; m++) lat[m] = 0;
    @(negedge clk);
    mode = md;
    arg = a;
    vin = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      vin = 1'b0;
      for (int m = 0; m < N; m++) if (lat[m] == 0 && vout[m]) lat[m] = k;
    end
    for (int m = 0; m < N; m++) chk("latency", m, lat[m], st_of(m));
  endtask

  initial begin
    logic [7:0] r, r2;
    logic e, e2;
    int base_acc [N], base_emit [N];
    bit saw [N];
    for (int m = 0; m < N; m++) begin
      dut_acc[m] = 0;
      dut_emit[m] = 0;
    end
    rstn = 1'b0;
    vin = 1'b1;
    mode = 2'b00;
    arg = 8'h05;
    cyc(4);
    for (int m = 0; m < N; m++) begin
      chk("rst_valid", m, vout[m], 0);
      chk("rst_result", m, res[m], 0);
      chk("rst_err", m, eout[m], 0);
      chk("rst_ready", m, rdy[m], 1);
      chk("rst_no_accept", m, dut_acc[m], 0);
    end
    rstn = 1'b1;
    @(negedge clk);
    vin = 1'b0;
    for (int m = 0; m < N; m++) chk("first_accept", m, dut_acc[m], 1);
    drain();

    for (int i = 0; i < 12; i++) begin
      chk("model_pin", i, ref_op(VECS[i].md, VECS[i].a), {VECS[i].e, VECS[i].r});
      run_one(VECS[i].md, VECS[i].a, r, e);
      chk("vec_result", i, r, VECS[i].r);
      chk("vec_err", i, e, VECS[i].e);
    end
    drain();

    for (int g = 0; g < 128; g++) begin
      run_one(2'b01, 8'(g), r, e);
      chk("sweep_err", g, e, 0);
      run_one(2'b00, r, r2, e2);
      chk("round_trip", g, r2, g);
    end
    drain();

    lat_check(2'b00, 8'h11);
    drain();

    for (int m = 0; m < N; m++) base_emit[m] = dut_emit[m];
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      vin = 1'b1;
      mode = 2'(i % 4);
      arg = 8'(i * 37);
    end
    @(negedge clk);
    vin = 1'b0;
    drain();
    for (int m = 0; m < N; m++) chk("stream_count", m, dut_emit[m] - base_emit[m], 16);

    for (int m = 0; m < N; m++) begin
      base_acc[m] = dut_acc[m];
      base_emit[m] = dut_emit[m];
      saw[m] = 1'b0;
    end
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      vin = 1'b1;
      mode = 2'(i % 3);
      arg = 8'(i * 23 + 5);
      rin = !(i >= 10 && i <= 12);
      #1;
      for (int m = 0; m < N; m++) if (!rdy[m]) saw[m] = 1'b1;
    end
    @(negedge clk);
    vin = 1'b0;
    rin = 1'b1;
    drain();
    for (int m = 0; m < N; m++) begin
      chk("stall_ready_fell", m, saw[m], 1);
      chk("stall_no_loss", m, dut_emit[m] - base_emit[m], dut_acc[m] - base_acc[m]);
    end

    @(negedge clk);
    vin = 1'b1;
    mode = 2'b00;
    arg = 8'h21;
    @(negedge clk);
    arg = 8'h32;
    @(negedge clk);
    vin = 1'b0;
    rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    for (int m = 0; m < N; m++) begin
      chk("post_rst_valid", m, vout[m], 0);
      base_emit[m] = dut_emit[m];
    end
    cyc(10);
    for (int m = 0; m < N; m++) chk("post_rst_nothing", m, dut_emit[m] - base_emit[m], 0);
    lat_check(2'b10, 8'hF0);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
